// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one sync FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          Clock,
  input  logic                          Fifo_rst,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_data,
  input  logic                          Full,
  output logic                          Write_enable,
  output logic [DATA_WIDTH-1:0]         Write_data,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [NUM_REQ-1:0]            Ack,
  output logic                          Busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  logic                 r_owner_valid;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_ptr;
  logic [BW-1:0]        r_beat;
  logic [NUM_REQ-1:0]   r_grant;

  logic                 w_req_own;
  logic                 w_we;
  logic                 w_rel;
  logic                 w_arb;
  logic                 w_found;
  logic [IW-1:0]        w_base;
  logic [IW-1:0]        w_win;
  logic [IW-1:0]        w_idx;

  assign w_req_own    = Req[r_owner];
  assign w_we         = r_owner_valid & w_req_own & ~Full;
  assign w_rel        = r_owner_valid & ((w_we & (r_beat == BW'(BURST_LEN - 1))) | ~w_req_own);
  assign w_arb        = ~r_owner_valid | w_rel;
  assign w_base       = r_owner_valid ? r_owner : r_ptr;
  assign Write_enable = w_we;
  assign Write_data   = w_we ? Req_data[r_owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign Ack          = NUM_REQ'(w_we) << r_owner;
  assign Grant        = r_grant;
  assign Busy         = r_owner_valid;

  // First requester after w_base with wrap; the base itself is checked last
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(w_base) + k) % NUM_REQ);
      if (Req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Ownership, beat count and round-robin pointer; re-arbitrate on the release edge
  always_ff @(posedge Clock or posedge Fifo_rst) begin
    if (Fifo_rst) begin
      r_owner_valid <= 1'b0;
      r_owner       <= '0;
      r_ptr         <= IW'(NUM_REQ - 1);
      r_beat        <= '0;
      r_grant       <= '0;
    end else if (w_arb) begin
      r_owner_valid <= w_found;
      r_owner       <= w_win;
      r_beat        <= '0;
      r_grant       <= NUM_REQ'(w_found) << w_win;
      if (w_rel) r_ptr <= r_owner;
    end else if (w_we) begin
      r_beat <= r_beat + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks against a behavioural arbiter model
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic              Clock = 1'b0;
  logic              Fifo_rst = 1'b0;
  logic [N-1:0]      Req = '0;
  logic [N*DW-1:0]   Req_data = '0;
  logic              Full = 1'b0;
  logic              Write_enable;
  logic [DW-1:0]     Write_data;
  logic [N-1:0]      Grant;
  logic [N-1:0]      Ack;
  logic              Busy;

  int checks = 0;
  int errors = 0;
  int nwr;
  int m_owner;
  int m_beat;
  int m_ptr;
  logic m_we;
  logic [DW-1:0] m_data [N];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .Clock(Clock), .Fifo_rst(Fifo_rst), .Req(Req), .Req_data(Req_data), .Full(Full),
    .Write_enable(Write_enable), .Write_data(Write_data), .Grant(Grant), .Ack(Ack), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_beat  = 0;
    m_ptr   = N - 1;
  endtask

  task automatic compare();
    m_we = (m_owner >= 0) && Req[m_owner] && !Full;
    check("we", 32'(Write_enable), 32'(m_we));
    check("wdata", 32'(Write_data), m_we ? 32'(m_data[m_owner]) : 32'd0);
    check("ack", 32'(Ack), m_we ? 32'(1 << m_owner) : 32'd0);
    check("grant", 32'(Grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
    check("busy", 32'(Busy), 32'(m_owner >= 0));
    if (Write_enable) nwr++;
  endtask

  task automatic m_edge();
    logic rel;
    if (Fifo_rst) m_reset();
    else if (m_owner < 0) begin
      m_owner = pick(m_ptr, Req);
      m_beat  = 0;
    end else begin
      rel = (m_we && m_beat == BL - 1) || !Req[m_owner];
      if (m_we) m_data[m_owner] = DW'($urandom);
      if (rel) begin
        m_ptr   = m_owner;
        m_owner = pick(m_owner, Req);
        m_beat  = 0;
      end else if (m_we) m_beat++;
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic f);
    Req  = r;
    Full = f;
    for (int i = 0; i < N; i++) Req_data[i*DW +: DW] = m_data[i];
  endtask

  task automatic step(input logic [N-1:0] r, input logic f);
    drive(r, f);
    #1;
    compare();
    @(posedge Clock);
    m_edge();
    #1;
  endtask

  task automatic do_reset();
    Fifo_rst = 1'b1;
    step('0, 1'b0);
    Fifo_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_data[i] = DW'($urandom);
    m_reset();
    #1;
    Fifo_rst = 1'b1;
    for (int i = 0; i < 3; i++) step(N'($urandom), 1'b0);
    Fifo_rst = 1'b0;

    nwr = 0;
    step(4'b0100, 1'b0);
    check("single_grant", 32'(Grant), 32'b0100);
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b0);
    check("single_writes", 32'(nwr), 32'd6);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    do_reset();
    nwr = 0;
    for (int i = 0; i <= 16; i++) begin
      step(4'b1111, 1'b0);
      check("rr_grant", 32'(Grant), 32'(1 << ((i / 4) % 4)));
    end
    check("rr_writes", 32'(nwr), 32'd16);
    step(4'b0000, 1'b0);

    do_reset();
    nwr = 0;
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
    check("full_pre", 32'(nwr), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 1'b1);
      check("full_grant", 32'(Grant), 32'b0010);
    end
    check("full_nowr", 32'(nwr), 32'd2);
    nwr = 0;
    for (int i = 0; i < 2; i++) step(4'b0010, 1'b0);
    check("full_post", 32'(nwr), 32'd2);
    step(4'b0000, 1'b0);

    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1001, 1'b0);
    step(4'b1000, 1'b0);
    check("early_grant", 32'(Grant), 32'b1000);
    nwr = 0;
    for (int i = 0; i < 5; i++) step(4'b1000, 1'b0);
    check("early_writes", 32'(nwr), 32'd5);
    step(4'b0000, 1'b0);

    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    #1;
    compare();
    Fifo_rst = 1'b1;
    #1;
    check("rst_we", 32'(Write_enable), 32'd0);
    check("rst_grant", 32'(Grant), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    m_reset();
    @(posedge Clock);
    #1;
    Fifo_rst = 1'b0;
    step(4'b0101, 1'b0);
    check("rst_regrant", 32'(Grant), 32'b0001);

    for (int i = 0; i < 400; i++) step(N'($urandom), ($urandom_range(0, 3) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
